// File: rtl/pixel_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// pixel_seq_ctrl_if -- control/strobe bundle between a frame host and the
// pixel sequencer.
//   start, continuous      host -> sequencer  frame request / free-run select
//   abort                  host -> sequencer  (only with PIXEL_SEQ_CTRL_ABORT_EN)
//   erase, expose, convert sequencer -> host  phase strobes
//   read[N_ROWS]           sequencer -> host  one-hot read group strobe
//   ramp_code[DATA_W]      sequencer -> host  ADC ramp value during convert
//   busy, done, frame_cnt  sequencer -> host  status
// Modports: master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface pixel_seq_ctrl_if #(
    parameter int N_ROWS = 2,
    parameter int DATA_W = 8
);
    logic                start;
    logic                continuous;
`ifdef PIXEL_SEQ_CTRL_ABORT_EN
    logic                abort;
`endif
    logic                erase;
    logic                expose;
    logic                convert;
    logic [N_ROWS-1:0]   read;
    logic [DATA_W-1:0]   ramp_code;
    logic                busy;
    logic                done;
    logic [15:0]         frame_cnt;

    modport master (
        output start, continuous,
`ifdef PIXEL_SEQ_CTRL_ABORT_EN
        output abort,
`endif
        input  erase, expose, convert, read, ramp_code, busy, done, frame_cnt
    );

    modport slave (
        input  start, continuous,
`ifdef PIXEL_SEQ_CTRL_ABORT_EN
        input  abort,
`endif
        output erase, expose, convert, read, ramp_code, busy, done, frame_cnt
    );
endinterface

// File: rtl/pixel_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_seq_ctrl -- frame sequencer for a pixel array:
//   IDLE -> ERASE -> EXPOSE -> CONVERT -> READ(group 0..N_ROWS-1) -> IDLE/ERASE
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    pixel_seq_ctrl_if.slave (start/continuous in, strobes/status out)
// Strobes are Moore decodes of the state register; ramp_code counts up from
// 0 while in CONVERT. Frame length is C_ERASE+C_EXPOSE+C_CONVERT+N_ROWS*C_READ.
// Optional feature: define PIXEL_SEQ_CTRL_ABORT_EN to add bus.abort, which
// returns a busy sequencer to IDLE with no done pulse or frame_cnt change.
// ---------------------------------------------------------------------------
module pixel_seq_ctrl #(
    parameter int N_ROWS    = 2,
    parameter int C_ERASE   = 5,
    parameter int C_EXPOSE  = 255,
    parameter int C_CONVERT = 255,
    parameter int C_READ    = 5,
    parameter int DATA_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    pixel_seq_ctrl_if.slave    bus
);
    // Phase counter only has to reach the longest phase length minus one.
    localparam int CMAX_A = (C_ERASE  > C_EXPOSE) ? C_ERASE  : C_EXPOSE;
    localparam int CMAX_B = (C_CONVERT > C_READ)  ? C_CONVERT : C_READ;
    localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
    localparam int PH_W   = (CMAX   > 1) ? $clog2(CMAX)   : 1;
    localparam int RW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [RW-1:0]       row_q, row_d;
    logic [DATA_W-1:0]   ramp_q, ramp_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                frame_end;
    logic                abort_req;

`ifdef PIXEL_SEQ_CTRL_ABORT_EN
    assign abort_req = bus.abort && (state_q != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // Last cycle of the last read group.
    assign frame_end = (state_q == S_READ) &&
                       (phase_q == PH_W'(C_READ - 1)) &&
                       (row_q == RW'(N_ROWS - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + PH_W'(1);
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                row_d   = '0;
                if (bus.start) state_d = S_ERASE;
            end
            S_ERASE: begin
                if (phase_q == PH_W'(C_ERASE - 1)) begin
                    state_d = S_EXPOSE;
                    phase_d = '0;
                end
            end
            S_EXPOSE: begin
                if (phase_q == PH_W'(C_EXPOSE - 1)) begin
                    state_d = S_CONVERT;
                    phase_d = '0;
                end
            end
            S_CONVERT: begin
                if (phase_q == PH_W'(C_CONVERT - 1)) begin
                    state_d = S_READ;
                    phase_d = '0;
                end
            end
            S_READ: begin
                if (phase_q == PH_W'(C_READ - 1)) begin
                    phase_d = '0;
                    if (row_q == RW'(N_ROWS - 1)) begin
                        row_d       = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        // Free-run goes straight back to ERASE, no IDLE gap.
                        state_d     = bus.continuous ? S_ERASE : S_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                row_d   = '0;
            end
        endcase
        // Abort overrides everything, including a completing frame.
        if (abort_req) begin
            state_d     = S_IDLE;
            phase_d     = '0;
            row_d       = '0;
            frame_cnt_d = frame_cnt_q;
        end
        // Ramp is 0 on the first convert cycle and advances only while we stay.
        ramp_d = ((state_q == S_CONVERT) && (state_d == S_CONVERT)) ?
                 ramp_q + DATA_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            row_q       <= '0;
            ramp_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            ramp_q      <= ramp_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.erase     = (state_q == S_ERASE);
    assign bus.expose    = (state_q == S_EXPOSE);
    assign bus.convert   = (state_q == S_CONVERT);
    assign bus.read      = (state_q == S_READ) ? (N_ROWS'(1) << row_q) : '0;
    assign bus.ramp_code = ramp_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = frame_end && !abort_req;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
module tb_pixel_seq_ctrl;
    logic clk;
    logic reset;

    pixel_seq_ctrl_if #(.N_ROWS(2), .DATA_W(8)) bus ();
    pixel_seq_ctrl_if #(.N_ROWS(1), .DATA_W(4)) wbus ();

    pixel_seq_ctrl u_dut (.clk(clk), .reset(reset), .bus(bus));

    pixel_seq_ctrl #(
        .N_ROWS(1), .C_ERASE(1), .C_EXPOSE(1), .C_CONVERT(20), .C_READ(1), .DATA_W(4)
    ) u_wrap (.clk(clk), .reset(reset), .bus(wbus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int err_vec, err_ramp, ndone, rmax;
    int done_t [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Expected {done,busy,erase,expose,convert,read[1:0]} at frame cycle p (0 = idle).
    function automatic logic [6:0] exp_vec(input int p);
        if (p >= 1   && p <= 5)   return 7'b0110000;
        if (p >= 6   && p <= 260) return 7'b0101000;
        if (p >= 261 && p <= 515) return 7'b0100100;
        if (p >= 516 && p <= 520) return 7'b0100001;
        if (p >= 521 && p <= 524) return 7'b0100010;
        if (p == 525)             return 7'b1100010;
        return 7'b0000000;
    endfunction

    // Start a frame and compare every cycle against the hand-derived timeline.
    task automatic run_frames(input int ncyc, input int nframes, input int pulse_at,
                              input int cont_until);
        int p;
        logic [6:0] ev, ov;
        logic [7:0] er;
        err_vec = 0; err_ramp = 0; ndone = 0; rmax = 0;
        for (int k = 0; k < 3; k++) done_t[k] = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.continuous = (cont_until > 0);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            p  = (i <= nframes * 525) ? ((i - 1) % 525) + 1 : 0;
            ev = exp_vec(p);
            ov = {bus.done, bus.busy, bus.erase, bus.expose, bus.convert, bus.read};
            if (ov !== ev) err_vec++;
            er = (p >= 261 && p <= 515) ? 8'(p - 261) : 8'd0;
            if (bus.ramp_code !== er) err_ramp++;
            if (int'(bus.ramp_code) > rmax) rmax = int'(bus.ramp_code);
            if (bus.done === 1'b1) begin
                if (ndone < 3) done_t[ndone] = i;
                ndone++;
            end
            bus.start      = (i == pulse_at) || (i == pulse_at + 1);
            bus.continuous = (i < cont_until);
        end
        bus.start = 1'b0;
        bus.continuous = 1'b0;
    endtask

    initial begin
        int cnt_busy, cnt_done, werr, wdone_at, saw_wrap;
        logic [3:0] wprev, wexp;
        logic [15:0] fc0;
        bus.start = 1'b0; bus.continuous = 1'b0;
        wbus.start = 1'b0; wbus.continuous = 1'b0;
`ifdef PIXEL_SEQ_CTRL_ABORT_EN
        bus.abort = 1'b0; wbus.abort = 1'b0;
`endif
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobes", {bus.erase, bus.expose, bus.convert}, 0);
        chk("rst_read", bus.read, 0);
        chk("rst_ramp", bus.ramp_code, 0);
        chk("rst_fcnt", bus.frame_cnt, 0);
        chk("rst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", bus.busy, 0);

        // Short-parameter instance: ramp wrap 15->0 and N_ROWS=1.
        werr = 0; wdone_at = 0; saw_wrap = 0; wprev = 4'd0;
        @(negedge clk);
        wbus.start = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            wbus.start = 1'b0;
            wexp = (i >= 3 && i <= 22) ? 4'((i - 3) % 16) : 4'd0;
            if (wbus.ramp_code !== wexp) werr++;
            if (wbus.convert !== ((i >= 3 && i <= 22) ? 1'b1 : 1'b0)) werr++;
            if (wbus.read !== ((i == 23) ? 1'b1 : 1'b0)) werr++;
            if (wbus.convert && wprev == 4'd15 && wbus.ramp_code == 4'd0) saw_wrap = 1;
            wprev = wbus.ramp_code;
            if (wbus.done === 1'b1) wdone_at = i;
        end
        chk("wrap_seq", werr, 0);
        chk("wrap_15_to_0", saw_wrap, 1);
        chk("wrap_done_at", wdone_at, 23);
        chk("wrap_fcnt", wbus.frame_cnt, 1);

        // Single frame.
        run_frames(530, 1, -10, 0);
        chk("f1_timeline", err_vec, 0);
        chk("f1_ramp", err_ramp, 0);
        chk("f1_ramp_max", rmax, 254);
        chk("f1_ndone", ndone, 1);
        chk("f1_done_at", done_t[0], 525);
        chk("f1_fcnt", bus.frame_cnt, 1);
        chk("f1_idle", bus.busy, 0);

        // Start re-pulsed during EXPOSE.
        run_frames(530, 1, 100, 0);
        chk("sb_timeline", err_vec, 0);
        chk("sb_ndone", ndone, 1);
        chk("sb_fcnt", bus.frame_cnt, 2);

        // Continuous mode for three frames.
        run_frames(1580, 3, -10, 1100);
        chk("cont_timeline", err_vec, 0);
        chk("cont_ndone", ndone, 3);
        chk("cont_done0", done_t[0], 525);
        chk("cont_gap1", done_t[1] - done_t[0], 525);
        chk("cont_gap2", done_t[2] - done_t[1], 525);
        chk("cont_fcnt", bus.frame_cnt, 5);

        // Reset asserted mid-CONVERT, between clock edges.
        cnt_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) cnt_done++;
        end
        chk("rm_in_convert", bus.convert, 1);
        #2 reset = 1'b0;
        #1;
        chk("rm_busy", bus.busy, 0);
        chk("rm_strobes", {bus.erase, bus.expose, bus.convert}, 0);
        chk("rm_read", bus.read, 0);
        chk("rm_ramp", bus.ramp_code, 0);
        chk("rm_fcnt", bus.frame_cnt, 0);
        chk("rm_done", bus.done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cnt_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) cnt_busy++;
            if (bus.done === 1'b1) cnt_done++;
        end
        chk("rm_stay_idle", cnt_busy, 0);
        chk("rm_no_done", cnt_done, 0);
        run_frames(530, 1, -10, 0);
        chk("rm_next_frame", err_vec, 0);
        chk("rm_next_fcnt", bus.frame_cnt, 1);

`ifdef PIXEL_SEQ_CTRL_ABORT_EN
        // Abort together with start in READ group 0.
        fc0 = bus.frame_cnt;
        cnt_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 518; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) cnt_done++;
        end
        chk("ab_in_read0", bus.read, 1);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("ab_busy", bus.busy, 0);
        chk("ab_read", bus.read, 0);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        cnt_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) cnt_busy++;
            if (bus.done === 1'b1) cnt_done++;
        end
        chk("ab_stay_idle", cnt_busy, 0);
        chk("ab_no_done", cnt_done, 0);
        chk("ab_fcnt", bus.frame_cnt, 32'(fc0));
`else
        fc0 = bus.frame_cnt;
        chk("fcnt_final", 32'(fc0), 1);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/pixel_seq_ctrl.md
PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 SHALL have parameter N_ROWS, default 2: number of read groups, one read strobe each, N_ROWS >= 1.
REQ-002 SHALL have parameter C_ERASE, default 5: erase phase length in cycles, >= 1.
REQ-003 SHALL have parameter C_EXPOSE, default 255: expose phase length in cycles, >= 1.
REQ-004 SHALL have parameter C_CONVERT, default 255: convert phase length in cycles, >= 1.
REQ-005 SHALL have parameter C_READ, default 5: cycles per read group, >= 1.
REQ-006 SHALL have parameter DATA_W, default 8: ramp code width.
REQ-007 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset  in  1: asynchronous, active-low (0 = reset).
REQ-009 SHALL have port start  in  1: frame request, sampled only in IDLE.
REQ-010 SHALL have port continuous  in  1: 1 = restart a frame automatically after the last read.
REQ-011 SHALL have port erase  out  1: photodiode erase strobe.
REQ-012 SHALL have port expose  out  1: exposure enable.
REQ-013 SHALL have port convert  out  1: ADC ramp phase enable.
REQ-014 SHALL have port read  out  N_ROWS: one-hot read strobe per group.
REQ-015 SHALL have port ramp_code  out  DATA_W: digital ramp driven onto the pixel data bus during convert.
REQ-016 SHALL have port busy  out  1: high in every state except IDLE.
REQ-017 SHALL have port done  out  1: single-cycle pulse at frame completion.
REQ-018 SHALL have port frame_cnt  out  16: completed-frame counter.

Function
REQ-019 SHALL implement the states IDLE, ERASE, EXPOSE, CONVERT and READ, with a phase counter and a row index.
REQ-020 SHALL decode erase, expose, convert and read combinationally from the state register (Moore outputs), with exactly one output high outside IDLE.
REQ-021 SHALL move IDLE->ERASE on the edge where start=1, so erase is high from the next cycle.
REQ-022 SHALL hold ERASE, EXPOSE and CONVERT for exactly C_ERASE, C_EXPOSE and C_CONVERT cycles, clearing the phase counter on each transition.
REQ-023 SHALL visit groups 0..N_ROWS-1 in order in READ, each for C_READ cycles, with read[row]=1 and all other bits 0.
REQ-024 SHALL set ramp_code to 0 on CONVERT entry, add 1 each convert cycle (wrapping modulo 2^DATA_W) and hold it at 0 outside CONVERT.
REQ-025 SHALL pulse done for one cycle and increment frame_cnt (wrapping 0xFFFF->0) on the final cycle of group N_ROWS-1.
REQ-026 SHALL sample continuous on that same final cycle: 1 -> next state ERASE with no IDLE gap; 0 -> next state IDLE.
REQ-027 SHALL ignore start while busy=1, neither queuing nor extending the current frame.
REQ-028 SHALL make the frame length exactly C_ERASE+C_EXPOSE+C_CONVERT+N_ROWS*C_READ cycles.

Reset
REQ-029 SHALL, on reset=0, immediately and asynchronously force state=IDLE and clear the phase counter, row index, ramp_code, frame_cnt and done, making erase=expose=convert=busy=0 and read=0.
REQ-030 SHALL, when reset asserts mid-frame, abandon the frame without a done pulse or frame_cnt increment.
REQ-031 SHALL, after reset releases, require a new start before any activity.

Configuration
REQ-032 SHALL, with macro PIXEL_SEQ_CTRL_ABORT_EN defined, add port abort  in  1: when abort=1 on any edge while busy, the next state is IDLE, all strobes drop, and there is no done pulse and no frame_cnt change.
REQ-033 SHALL give abort priority over start and continuous when they coincide.
REQ-034 SHALL, without PIXEL_SEQ_CTRL_ABORT_EN, have no abort port and keep behaviour otherwise identical.

Verification (defaults: C_ERASE=5, C_EXPOSE=255, C_CONVERT=255, C_READ=5, N_ROWS=2)
REQ-035 SHALL cover a single frame: start pulse with continuous=0 -> erase 5, expose 255, convert 255, read[0] 5, read[1] 5 cycles; done once at cycle 525; frame_cnt=1; return to IDLE.
REQ-036 SHALL cover the ramp: ramp_code reaches 0..254 during convert; with DATA_W=4, ramp_code wraps 15->0.
REQ-037 SHALL cover continuous mode: continuous=1 for 3 frames -> erase follows read[1] with no IDLE cycle; busy stays high; frame_cnt=3; done pulses 525 cycles apart.
REQ-038 SHALL cover start while busy: start re-pulsed during EXPOSE -> no effect; the frame still lasts 525 cycles; frame_cnt increments by 1.
REQ-039 SHALL cover reset mid-frame: reset=0 during CONVERT -> all outputs 0 at once; frame_cnt=0; no done pulse; IDLE until the next start.
REQ-040 SHALL cover abort (macro defined): abort and start asserted together during READ group 0 -> IDLE next cycle; no done pulse; frame_cnt unchanged.
